// File: rtl/bp_fpga_host_nbf_rx.sv
// Assembles UART bytes (opcode, address LSB-first, data LSB-first) into one NBF packet.
// nbf_v_o rises 1 cycle after the last byte; no bytes are accepted while a packet is held.
module bp_fpga_host_nbf_rx #(
    parameter int nbf_addr_width_p = 40,
    parameter int nbf_data_width_p = 64,
    parameter int timeout_cycles_p = 2000000
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [7:0]                  byte_i,
    input  logic                        byte_v_i,
    output logic                        byte_ready_and_o,
    input  logic                        byte_err_i,
    output logic [7:0]                  nbf_opcode_o,
    output logic [nbf_addr_width_p-1:0] nbf_addr_o,
    output logic [nbf_data_width_p-1:0] nbf_data_o,
    output logic                        nbf_v_o,
    input  logic                        nbf_yumi_i,
    output logic                        error_o,
    output logic [7:0]                  drop_count_o
);

    localparam int addr_bytes = nbf_addr_width_p / 8;
    localparam int pkt_bytes  = 1 + addr_bytes + nbf_data_width_p / 8;
    localparam int cnt_w      = $clog2(pkt_bytes);
    localparam int tmo_w      = $clog2(timeout_cycles_p + 1);

    typedef enum logic {COLLECT, FULL} state_e;

    state_e                 state, state_n;
    logic [cnt_w-1:0]       cnt;
    logic [tmo_w-1:0]       tmo;
    logic [pkt_bytes*8-1:0] pkt;
    logic                   ready;
    logic                   xfer;
    logic                   last;
    logic                   timeout;
    logic                   evt;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= COLLECT;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        ready   = 1'b0;
        xfer    = 1'b0;
        last    = (cnt == cnt_w'(pkt_bytes - 1));
        timeout = 1'b0;
        case (state)
            COLLECT: begin
                ready   = 1'b1;
                xfer    = byte_v_i;
                // An accepted byte restarts the idle window, so it can never coincide with a timeout.
                timeout = (cnt != '0) && !byte_v_i && (tmo == tmo_w'(timeout_cycles_p - 1));
                if (byte_v_i && last && !byte_err_i) state_n = FULL;
            end
            FULL: begin
                if (nbf_yumi_i) state_n = COLLECT;
            end
            default: state_n = COLLECT;
        endcase
        evt = byte_err_i | timeout;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt          <= '0;
            tmo          <= '0;
            pkt          <= '0;
            error_o      <= 1'b0;
            drop_count_o <= 8'd0;
        end else begin
            error_o <= evt;
            if (evt && drop_count_o != 8'hff) drop_count_o <= drop_count_o + 8'd1;
            if (state == COLLECT) begin
                if (evt) begin
                    cnt <= '0;
                    tmo <= '0;
                end else if (xfer) begin
                    tmo <= '0;
                    cnt <= last ? '0 : cnt + cnt_w'(1);
                    for (int i = 0; i < pkt_bytes; i++) begin
                        if (cnt == cnt_w'(i)) pkt[i*8 +: 8] <= byte_i;
                    end
                end else if (cnt != '0) begin
                    tmo <= tmo + tmo_w'(1);
                end
            end
        end
    end

    assign byte_ready_and_o = ready & ~reset_i;
    assign nbf_v_o          = (state == FULL);
    assign nbf_opcode_o     = pkt[7:0];
    assign nbf_addr_o       = pkt[8 +: nbf_addr_width_p];
    assign nbf_data_o       = pkt[8 + nbf_addr_width_p +: nbf_data_width_p];

endmodule

// File: tb/tb_bp_fpga_host_nbf_rx.sv
// Directed bench for bp_fpga_host_nbf_rx with 40-bit address (14-byte packets) and a 100-cycle timeout.
module tb_bp_fpga_host_nbf_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_v = 1'b0;
    logic        byte_rdy;
    logic        byte_err = 1'b0;
    logic [7:0]  opcode;
    logic [39:0] addr;
    logic [63:0] data;
    logic        nbf_v;
    logic        yumi = 1'b0;
    logic        err_pulse;
    logic [7:0]  drops;

    int total = 0;
    int bad = 0;
    int pulses = 0;

    bp_fpga_host_nbf_rx #(
        .nbf_addr_width_p(40),
        .nbf_data_width_p(64),
        .timeout_cycles_p(100)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .byte_i          (byte_in),
        .byte_v_i        (byte_v),
        .byte_ready_and_o(byte_rdy),
        .byte_err_i      (byte_err),
        .nbf_opcode_o    (opcode),
        .nbf_addr_o      (addr),
        .nbf_data_o      (data),
        .nbf_v_o         (nbf_v),
        .nbf_yumi_i      (yumi),
        .error_o         (err_pulse),
        .drop_count_o    (drops)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (err_pulse) pulses++;

    typedef struct {
        logic [0:13][7:0] bytes;
        logic [7:0]       op;
        logic [39:0]      ad;
        logic [63:0]      dt;
    } vec_t;

    vec_t tbl[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic e);
        int n;
        byte_in  = b;
        byte_v   = 1'b1;
        byte_err = e;
        n = 0;
        while (!byte_rdy && n < 200) begin
            tick();
            n++;
        end
        if (!byte_rdy) begin
            total++;
            bad++;
            $display("FAIL ready_wait: got 0 expected 1 within 200 cycles");
        end
        tick();
        byte_v   = 1'b0;
        byte_err = 1'b0;
    endtask

    task automatic send_range(input int idx, input int first, input int last_b);
        for (int i = first; i <= last_b; i++) send_byte(tbl[idx].bytes[i], 1'b0);
    endtask

    task automatic check_pkt(input int idx, input string name);
        chk({name, "_v"},    {63'd0, nbf_v}, 64'd1);
        chk({name, "_op"},   {56'd0, opcode}, {56'd0, tbl[idx].op});
        chk({name, "_addr"}, {24'd0, addr},   {24'd0, tbl[idx].ad});
        chk({name, "_data"}, data, tbl[idx].dt);
    endtask

    task automatic take();
        yumi = 1'b1;
        tick();
        yumi = 1'b0;
        chk("after_yumi_v", {63'd0, nbf_v}, 64'd0);
        chk("after_yumi_rdy", {63'd0, byte_rdy}, 64'd1);
    endtask

    initial begin
        int stuck;
        int p0;

        tbl[0].bytes = {8'h02, 8'h00, 8'h10, 8'h00, 8'h80, 8'h00,
                        8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        tbl[0].op = 8'h02; tbl[0].ad = 40'h0080001000; tbl[0].dt = 64'h0807060504030201;
        tbl[1].bytes = {8'h01, 8'hff, 8'hee, 8'hdd, 8'hcc, 8'hbb,
                        8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        tbl[1].op = 8'h01; tbl[1].ad = 40'hbbccddeeff; tbl[1].dt = 64'h8877665544332211;
        tbl[2].bytes = {8'hff, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
                        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
        tbl[2].op = 8'hff; tbl[2].ad = 40'h0000000001; tbl[2].dt = 64'h8000000000000000;
        tbl[3].bytes = {8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9a,
                        8'hde, 8'had, 8'hbe, 8'hef, 8'hca, 8'hfe, 8'hba, 8'hbe};
        tbl[3].op = 8'h03; tbl[3].ad = 40'h9a78563412; tbl[3].dt = 64'hbebafecaefbeadde;

        // Reset state
        #1;
        chk("rst_rdy",   {63'd0, byte_rdy}, 64'd0);
        chk("rst_v",     {63'd0, nbf_v}, 64'd0);
        chk("rst_drops", {56'd0, drops}, 64'd0);
        chk("rst_err",   {63'd0, err_pulse}, 64'd0);
        chk("rst_data",  data, 64'd0);
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("post_rst_rdy", {63'd0, byte_rdy}, 64'd1);
        tick();

        // Table of packets: decode, hold stability, handshake
        for (int k = 0; k < 4; k++) begin
            send_range(k, 0, 13);
            check_pkt(k, "pkt");
            tick(); tick(); tick();
            check_pkt(k, "hold");
            chk("hold_rdy", {63'd0, byte_rdy}, 64'd0);
            take();
        end

        // Backpressure while FULL: offered bytes must not be consumed
        send_range(0, 0, 13);
        byte_in = 8'haa;
        byte_v  = 1'b1;
        stuck = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (byte_rdy || !nbf_v) stuck++;
        end
        chk("full_block", stuck, 0);
        chk("full_keep_data", data, tbl[0].dt);
        byte_v = 1'b0;
        take();
        send_range(1, 0, 13);
        check_pkt(1, "after_bp");
        take();

        // yumi with no packet held is ignored mid-collection
        send_range(2, 0, 2);
        yumi = 1'b1;
        tick();
        yumi = 1'b0;
        chk("stray_yumi_v", {63'd0, nbf_v}, 64'd0);
        send_range(2, 3, 13);
        check_pkt(2, "stray_yumi");
        take();

        // Timeout of a 5-byte partial packet
        p0 = pulses;
        send_range(3, 0, 4);
        for (int i = 0; i < 99; i++) tick();
        chk("tmo_early_drops", {56'd0, drops}, 64'd0);
        tick();
        chk("tmo_drops", {56'd0, drops}, 64'd1);
        chk("tmo_err", {63'd0, err_pulse}, 64'd1);
        for (int i = 0; i < 5; i++) tick();
        chk("tmo_pulses", pulses - p0, 1);
        send_range(3, 0, 13);
        check_pkt(3, "after_tmo");
        take();

        // Reset after 7 bytes
        send_range(1, 0, 6);
        p0 = pulses;
        reset = 1'b1;
        #1;
        chk("midrst_op",    {56'd0, opcode}, 64'd0);
        chk("midrst_addr",  {24'd0, addr}, 64'd0);
        chk("midrst_drops", {56'd0, drops}, 64'd0);
        chk("midrst_rdy",   {63'd0, byte_rdy}, 64'd0);
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("midrst_rdy_after", {63'd0, byte_rdy}, 64'd1);
        tick(); tick();
        chk("midrst_no_err", pulses - p0, 0);
        send_range(1, 0, 13);
        check_pkt(1, "after_rst");
        take();

        // Error on the final byte; error while FULL
        send_range(0, 0, 12);
        send_byte(tbl[0].bytes[13], 1'b1);
        chk("lasterr_v",     {63'd0, nbf_v}, 64'd0);
        chk("lasterr_drops", {56'd0, drops}, 64'd1);
        chk("lasterr_err",   {63'd0, err_pulse}, 64'd1);
        send_range(0, 0, 13);
        byte_err = 1'b1;
        tick();
        byte_err = 1'b0;
        tick();
        check_pkt(0, "fullerr");
        chk("fullerr_drops", {56'd0, drops}, 64'd2);
        take();

        // Saturation of the drop counter
        byte_err = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        byte_err = 1'b0;
        tick();
        chk("sat_drops", {56'd0, drops}, 64'd255);
        send_range(2, 0, 13);
        check_pkt(2, "after_sat");
        chk("sat_hold_drops", {56'd0, drops}, 64'd255);
        take();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bp_fpga_host_nbf_rx.md
BP_FPGA_HOST_NBF_RX -- requirements
Module: bp_fpga_host_nbf_rx

Interface
REQ-001: Parameter nbf_addr_width_p, default 40, NBF address width in bits; SHALL be a multiple of 8.
REQ-002: Parameter nbf_data_width_p, default 64, NBF data width in bits; SHALL equal 64.
REQ-003: Parameter timeout_cycles_p, default 2000000, idle-cycle limit for a partial packet; SHALL be at least 2.
REQ-004: clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-005: reset_i  input  1  asynchronous, active-high reset.
REQ-006: byte_i  input  8  received UART byte.
REQ-007: byte_v_i  input  1  byte_i valid.
REQ-008: byte_ready_and_o  output  1  block accepts byte_i; a transfer occurs when byte_v_i & byte_ready_and_o.
REQ-009: byte_err_i  input  1  single-cycle UART framing/parity error strobe.
REQ-010: nbf_opcode_o  output  8  assembled NBF opcode.
REQ-011: nbf_addr_o  output  nbf_addr_width_p  assembled NBF address.
REQ-012: nbf_data_o  output  64  assembled NBF data.
REQ-013: nbf_v_o  output  1  assembled packet valid.
REQ-014: nbf_yumi_i  input  1  consumer takes the packet; legal only while nbf_v_o=1.
REQ-015: error_o  output  1  one-cycle pulse per discard or error event.
REQ-016: drop_count_o  output  8  saturating count of error events.

Function
REQ-017: Packet length N = 1 + nbf_addr_width_p/8 + 8 bytes; byte order: opcode, then address LSB-first, then data LSB-first.
REQ-018: Two states: COLLECT (byte counter 0..N-1) and FULL (packet held).
REQ-019: In COLLECT, byte_ready_and_o=1; each transfer writes byte k into its field slot and increments the counter.
REQ-020: The transfer of byte N-1 moves to FULL on the next edge, resets the counter to 0, and sets nbf_v_o=1; latency from the last byte to nbf_v_o is 1 cycle.
REQ-021: In FULL, byte_ready_and_o=0 and the nbf_*_o outputs are held stable until nbf_yumi_i.
REQ-022: nbf_yumi_i in FULL returns to COLLECT next cycle, with nbf_v_o=0 and byte_ready_and_o=1 next cycle; there is no same-cycle bypass.
REQ-023: The timeout counter clears on every accepted byte and increments each cycle in COLLECT with counter != 0.
REQ-024: The timeout counter is idle at counter=0 and in FULL.
REQ-025: When the timeout counter reaches timeout_cycles_p, the partial packet is discarded: counter to 0, error_o pulses, drop_count_o increments.
REQ-026: byte_err_i in COLLECT discards any partial packet (counter to 0), pulses error_o and increments drop_count_o, including when counter=0.
REQ-027: byte_err_i in the same cycle as a transfer drops that byte as well; an error on the would-be final byte SHALL NOT produce a packet.
REQ-028: byte_err_i in FULL pulses error_o and increments drop_count_o; the held packet and nbf_v_o are unaffected.
REQ-029: byte_err_i and timeout in the same cycle count as one event (single increment, single pulse).
REQ-030: drop_count_o saturates at 255 and never wraps.
REQ-031: nbf_yumi_i while nbf_v_o=0 is ignored.

Reset
REQ-032: On reset_i assertion, asynchronously: state COLLECT, byte counter 0, timeout counter 0, nbf_v_o=0, error_o=0, drop_count_o=0, and nbf_opcode_o/nbf_addr_o/nbf_data_o=0.
REQ-033: byte_ready_and_o=0 while reset_i is high, and 1 on the first cycle after deassertion.
REQ-034: Reset mid-packet or in FULL discards all content without raising error_o.

Verification (nbf_addr_width_p=40, N=14, timeout_cycles_p=100)
REQ-035: Bytes 02, 00 10 00 80 00, 01..08 back-to-back -> one cycle later nbf_v_o=1, opcode=0x02, addr=0x0080001000, data=0x0807060504030201; outputs stable until yumi.
REQ-036: Hold nbf_yumi_i low 50 cycles with byte_v_i=1 -> byte_ready_and_o=0 for the whole window and no bytes consumed; yumi -> byte_ready_and_o=1 next cycle and the next packet assembles correctly.
REQ-037: Send 5 bytes, then idle 100 cycles -> error_o pulses once, drop_count_o=1, and a following full 14-byte packet decodes correctly.
REQ-038: byte_err_i together with byte 14 -> no nbf_v_o, drop_count_o=1; byte_err_i during FULL -> packet intact, drop_count_o=2.
REQ-039: 300 byte_err_i strobes -> drop_count_o=255.
REQ-040: Reset asserted after 7 bytes -> all outputs zero immediately, no error_o pulse; a subsequent packet decodes correctly.
